icache_refill_ctrl: RTL and testbench

//  Miss handler sitting between the instruction cache and IRAM. On a fetch miss it reads one

---
 rtl/icache_refill_ctrl_pkg.sv | 31 +++
 rtl/icache_refill_ctrl_if.sv | 42 ++++
 rtl/icache_refill_buf.sv | 55 +++++
 rtl/icache_refill_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_icache_refill_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/icache_refill_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : icache_pkg
//  Description : Shared types and derived constants for the instruction-cache
//                refill controller. Holds the refill FSM state type and the
//                default block geometry (128-bit block, 32-bit IRAM word,
//                32-bit byte address).
//  Build macro : ICACHE_REFILL_CWF_EN (used by icache_refill_ctrl, not here)
//  Revision    : 1.0 - initial release
// ============================================================================
package icache_pkg;

    localparam int ICACHE_BLOCK_BITS = 128;
    localparam int ICACHE_WORD_BITS  = 32;
    localparam int ICACHE_PC_W       = 32;

    // Geometry derived from the defaults above
    localparam int NWORDS = ICACHE_BLOCK_BITS / ICACHE_WORD_BITS;
    localparam int OFF_W  = $clog2(ICACHE_BLOCK_BITS / 8);
    localparam int CNT_W  = $clog2(NWORDS);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } refill_state_t;

endpackage : icache_pkg
`default_nettype wire

// File: rtl/icache_refill_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Interface   : icache_refill_ctrl_if
//  Description : IRAM read channel used by the refill controller.
//                iram_req    - read request, held with iram_addr until gnt
//                iram_addr   - word-aligned byte address
//                iram_gnt    - request accepted this cycle
//                iram_rvalid - iram_rdata valid (earliest cycle after gnt)
//                iram_rdata  - little-endian read word
//                modport master : refill controller side
//                modport slave  : IRAM side
//  Revision    : 1.0 - initial release
// ============================================================================
interface icache_refill_ctrl_if #(
    parameter int PC_W      = 32,
    parameter int WORD_BITS = 32
);

    logic                 iram_req;
    logic [PC_W-1:0]      iram_addr;
    logic                 iram_gnt;
    logic                 iram_rvalid;
    logic [WORD_BITS-1:0] iram_rdata;

    modport master (
        output iram_req,
        output iram_addr,
        input  iram_gnt,
        input  iram_rvalid,
        input  iram_rdata
    );

    modport slave (
        input  iram_req,
        input  iram_addr,
        output iram_gnt,
        output iram_rvalid,
        output iram_rdata
    );

endinterface : icache_refill_ctrl_if
`default_nettype wire

// File: rtl/icache_refill_buf.sv
`default_nettype none
// ============================================================================
//  Module      : icache_refill_buf
//  Description : NWORDS-slot block register for the icache refill path.
//                Writes one IRAM word into an indexed slot and presents the
//                whole block in the cache byte layout: byte b of slot i lands
//                on block_out[WORD_BITS*i+8b +: 8] with the byte MSB at the
//                lowest index. All slots clear asynchronously on nrst.
//  Ports       : clk, nrst         - clock, async active-low reset
//                wr_en             - write wr_data into slot wr_idx
//                wr_idx, wr_data   - slot index and little-endian word
//                block_out         - assembled block [0:BLOCK_BITS-1]
//  Revision    : 1.0 - initial release
// ============================================================================
module icache_refill_buf #(
    parameter int BLOCK_BITS = 128,
    parameter int WORD_BITS  = 32,
    parameter int IDX_W      = 2
) (
    input  wire logic                  clk,
    input  wire logic                  nrst,
    input  wire logic                  wr_en,
    input  wire logic [IDX_W-1:0]      wr_idx,
    input  wire logic [WORD_BITS-1:0]  wr_data,
    output logic      [0:BLOCK_BITS-1] block_out
);

    localparam int c_nwords = BLOCK_BITS / WORD_BITS;
    localparam int c_nbytes = WORD_BITS / 8;

    logic [WORD_BITS-1:0] r_slot [c_nwords];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < c_nwords; i++) begin
                r_slot[i] <= '0;
            end
        end else if (wr_en) begin
            r_slot[wr_idx] <= wr_data;
        end
    end

    // Byte remap: the IRAM word is little-endian with descending bit order,
    // the cache block is ascending with the byte MSB first, so each byte
    // keeps its position but its bits are mirrored.
    for (genvar i = 0; i < c_nwords; i++) begin : g_slot
        for (genvar b = 0; b < c_nbytes; b++) begin : g_byte
            for (genvar j = 0; j < 8; j++) begin : g_bit
                assign block_out[WORD_BITS*i + 8*b + j] = r_slot[i][8*b + 7 - j];
            end
        end
    end

endmodule : icache_refill_buf
`default_nettype wire

// File: rtl/icache_refill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : icache_refill_ctrl
//  Description : Instruction-cache miss handler. On a fetch miss it reads one
//                cache block from IRAM word by word over req/gnt/rvalid,
//                assembles it in the cache byte layout and pulses cache_we
//                for one cycle with the block on block_out. Fetch is stalled
//                while the refill runs. A flush aborts the refill; an already
//                granted read is drained and discarded.
//  Build macro : ICACHE_REFILL_CWF_EN - critical word first: the refill
//                starts at the missing word and wraps inside the block.
//                Undefined: words are always fetched in slot order.
//  Ports       : clk, nrst          - clock, async active-low reset
//                fetch_valid, pc    - fetch request and its byte address
//                hit                - cache hit for pc
//                flush              - single-cycle refill abort
//                stall              - freeze fetch/pc
//                cache_we           - one-cycle cache write strobe
//                block_out          - assembled block, valid with cache_we
//                iram               - IRAM read channel (master modport)
//  Revision    : 1.0 - initial release
// ============================================================================
module icache_refill_ctrl
    import icache_pkg::*;
#(
    parameter int BLOCK_BITS = ICACHE_BLOCK_BITS,
    parameter int WORD_BITS  = ICACHE_WORD_BITS,
    parameter int PC_W       = ICACHE_PC_W
) (
    input  wire logic                  clk,
    input  wire logic                  nrst,
    input  wire logic                  fetch_valid,
    input  wire logic [PC_W-1:0]       pc,
    input  wire logic                  hit,
    input  wire logic                  flush,
    output logic                       stall,
    output logic                       cache_we,
    output logic      [0:BLOCK_BITS-1] block_out,
    icache_refill_ctrl_if.master       iram
);

    // Slot arithmetic relies on natural wrap, so the word count per block
    // must be a power of two (always true for power-of-two block/word sizes).
    localparam int c_nwords = BLOCK_BITS / WORD_BITS;
    localparam int c_off_w  = $clog2(BLOCK_BITS / 8);
    localparam int c_cnt_w  = $clog2(c_nwords);
    localparam int c_wb_w   = $clog2(WORD_BITS / 8);
    localparam int c_tag_w  = PC_W - c_off_w;

    localparam logic [c_cnt_w-1:0] c_last_beat = c_cnt_w'(c_nwords - 1);
    localparam logic [c_cnt_w-1:0] c_one       = c_cnt_w'(1);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    refill_state_t        r_state;
    logic [c_cnt_w-1:0]   r_beat_cnt;
    logic [c_tag_w-1:0]   r_miss_base;   // block-aligned miss address, offset bits dropped
    logic [c_cnt_w-1:0]   r_start;       // slot fetched on beat 0

    refill_state_t        w_state_nxt;
    logic [c_cnt_w-1:0]   w_beat_cnt_nxt;
    logic [c_tag_w-1:0]   w_miss_base_nxt;
    logic [c_cnt_w-1:0]   w_start_nxt;
    logic                 w_buf_we;
    logic [c_cnt_w-1:0]   w_slot;
    logic [c_cnt_w-1:0]   w_pc_start;
    logic                 w_miss;
    logic                 w_unused_pc;

    // ------------------------------------------------------------------
    // Beat-0 slot selection
    // ------------------------------------------------------------------
`ifdef ICACHE_REFILL_CWF_EN
    assign w_pc_start  = pc[c_off_w-1:c_wb_w];
    assign w_unused_pc = ^pc[c_wb_w-1:0];
`else
    assign w_pc_start  = '0;
    assign w_unused_pc = ^pc[c_off_w-1:0];
`endif

    // Slot for the current beat; wraps inside the block so the request
    // address can never leave it.
    assign w_slot = r_start + r_beat_cnt;
    assign w_miss = fetch_valid & ~hit;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_beat_cnt  <= '0;
            r_miss_base <= '0;
            r_start     <= '0;
        end else begin
            r_beat_cnt  <= w_beat_cnt_nxt;
            r_miss_base <= w_miss_base_nxt;
            r_start     <= w_start_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_beat_cnt_nxt  = r_beat_cnt;
        w_miss_base_nxt = r_miss_base;
        w_start_nxt     = r_start;
        w_buf_we        = 1'b0;
        stall           = 1'b0;
        cache_we        = 1'b0;
        iram.iram_req   = 1'b0;
        iram.iram_addr  = '0;

        case (r_state)
            IDLE: begin
                // Stall already in the miss cycle so fetch holds pc
                stall = w_miss;
                if (w_miss && !flush) begin
                    w_miss_base_nxt = pc[PC_W-1:c_off_w];
                    w_start_nxt     = w_pc_start;
                    w_beat_cnt_nxt  = '0;
                    w_state_nxt     = REQ;
                end
            end

            REQ: begin
                stall          = 1'b1;
                iram.iram_req  = 1'b1;
                iram.iram_addr = {r_miss_base, w_slot, {c_wb_w{1'b0}}};
                if (flush) begin
                    // A granted read still owes us an rvalid; drain it so it
                    // cannot be mistaken for data of a later refill.
                    w_state_nxt = iram.iram_gnt ? DRAIN : IDLE;
                end else if (iram.iram_gnt) begin
                    w_state_nxt = WAIT;
                end
            end

            WAIT: begin
                stall = 1'b1;
                if (flush) begin
                    w_state_nxt = iram.iram_rvalid ? IDLE : DRAIN;
                end else if (iram.iram_rvalid) begin
                    w_buf_we = 1'b1;
                    if (r_beat_cnt == c_last_beat) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_beat_cnt_nxt = r_beat_cnt + c_one;
                        w_state_nxt    = REQ;
                    end
                end
            end

            DRAIN: begin
                stall = 1'b1;
                if (iram.iram_rvalid) begin
                    w_state_nxt = IDLE;
                end
            end

            DONE: begin
                // Block is complete for miss_base, so a flush here is moot.
                // Stall is released: the cache forwards block_out this cycle.
                cache_we    = 1'b1;
                w_state_nxt = IDLE;
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Block assembly
    // ------------------------------------------------------------------
    icache_refill_buf #(
        .BLOCK_BITS (BLOCK_BITS),
        .WORD_BITS  (WORD_BITS),
        .IDX_W      (c_cnt_w)
    ) u_buf (
        .clk       (clk),
        .nrst      (nrst),
        .wr_en     (w_buf_we),
        .wr_idx    (w_slot),
        .wr_data   (iram.iram_rdata),
        .block_out (block_out)
    );

endmodule : icache_refill_ctrl
`default_nettype wire

// File: tb/tb_icache_refill_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_icache_refill_ctrl
//  Description : Self-checking bench for icache_refill_ctrl. An IRAM model
//                with per-beat grant/rvalid delays answers requests; expected
//                addresses, block contents and refill latency are computed
//                from the block/byte-layout rules with plain arithmetic.
//  Build macro : ICACHE_REFILL_CWF_EN selects critical-word-first ordering
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_refill_ctrl;

    localparam int BB = 128;
    localparam int WB = 32;
    localparam int PW = 32;
    localparam int NW = BB / WB;
`ifdef ICACHE_REFILL_CWF_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          nrst = 1'b1;
    logic          fetch_valid = 1'b0;
    logic          hit = 1'b0;
    logic          flush = 1'b0;
    logic [PW-1:0] pc = '0;
    logic          stall;
    logic          cache_we;
    logic [0:BB-1] block_out;

    icache_refill_ctrl_if #(.PC_W(PW), .WORD_BITS(WB)) bus ();

    icache_refill_ctrl #(.BLOCK_BITS(BB), .WORD_BITS(WB), .PC_W(PW)) dut (
        .clk         (clk),
        .nrst        (nrst),
        .fetch_valid (fetch_valid),
        .pc          (pc),
        .hit         (hit),
        .flush       (flush),
        .stall       (stall),
        .cache_we    (cache_we),
        .block_out   (block_out),
        .iram        (bus)
    );

    always #5 clk = ~clk;

    int          n_pass = 0;
    int          n_total = 0;
    int          gnt_dly [16];
    int          rv_dly  [16];
    int          n_grants = 0;
    int          addr_changes = 0;
    logic [31:0] grant_q [$];
    logic [31:0] mem_seed = 32'h0;
    bit          use_ovr = 1'b0;

    // IRAM content: pseudo-random per address, with one pinned word
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (use_ovr && a == 32'h0000_0100) return 32'h1122_3344;
        return (a * 32'h9E37_79B1) ^ mem_seed;
    endfunction

    function automatic logic [31:0] exp_addr(input logic [31:0] a, input int k);
        int start;
        start = CWF ? int'(a[3:2]) : 0;
        return {a[31:4], 4'h0} + 32'(4 * ((start + k) % NW));
    endfunction

    function automatic logic [0:BB-1] exp_block(input logic [31:0] a);
        logic [0:BB-1] blk;
        logic [31:0]   w;
        blk = '0;
        for (int i = 0; i < NW; i++) begin
            w = mem_word({a[31:4], 4'h0} + 32'(4 * i));
            for (int b = 0; b < 4; b++) blk[32*i + 8*b +: 8] = w[8*b +: 8];
        end
        return blk;
    endfunction

    // ---------------- IRAM responder ----------------
    int          req_age = 0;
    bit          rv_pend = 1'b0;
    int          rv_cnt = 0;
    logic [31:0] rv_addr = '0;
    bit          prev_hold = 1'b0;
    logic [31:0] prev_addr = '0;

    initial begin : iram_model
        bus.iram_gnt    = 1'b0;
        bus.iram_rvalid = 1'b0;
        bus.iram_rdata  = '0;
        forever begin
            @(negedge clk);
            bus.iram_gnt    = 1'b0;
            bus.iram_rvalid = 1'b0;
            if (bus.iram_req && prev_hold && bus.iram_addr !== prev_addr) addr_changes++;
            if (rv_pend) begin
                if (rv_cnt == 0) begin
                    bus.iram_rvalid = 1'b1;
                    bus.iram_rdata  = mem_word(rv_addr);
                    rv_pend         = 1'b0;
                end else begin
                    rv_cnt--;
                end
            end
            if (bus.iram_req && !rv_pend) begin
                if (req_age >= gnt_dly[n_grants % 16]) begin
                    bus.iram_gnt = 1'b1;
                    grant_q.push_back(bus.iram_addr);
                    rv_pend = 1'b1;
                    rv_cnt  = rv_dly[n_grants % 16];
                    rv_addr = bus.iram_addr;
                    n_grants++;
                    req_age = 0;
                end else begin
                    req_age++;
                end
            end else if (!bus.iram_req) begin
                req_age = 0;
            end
            prev_hold = bus.iram_req && !bus.iram_gnt;
            prev_addr = bus.iram_addr;
        end
    end

    task automatic clear_cfg();
        for (int i = 0; i < 16; i++) begin
            gnt_dly[i] = 0;
            rv_dly[i]  = 0;
        end
        n_grants     = 0;
        addr_changes = 0;
        grant_q.delete();
    endtask

    // Drives one miss at a negedge (cycle 0) and observes until cache_we
    task automatic run_miss(input logic [31:0] a, output int we_cyc,
                            output logic [0:BB-1] blk, output int stall_bad,
                            output int we_cnt);
        we_cyc = -1; blk = '0; stall_bad = 0; we_cnt = 0;
        @(negedge clk);
        pc = a; fetch_valid = 1'b1; hit = 1'b0;
        #1;
        if (stall !== 1'b1) stall_bad++;
        for (int cyc = 1; cyc <= 300 && we_cyc < 0; cyc++) begin
            @(negedge clk);
            if (cache_we === 1'b1) begin
                we_cyc = cyc; we_cnt++; blk = block_out;
                fetch_valid = 1'b0;
            end else if (stall !== 1'b1) begin
                stall_bad++;
            end
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (cache_we === 1'b1) we_cnt++;
            if (stall !== 1'b0) stall_bad++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #3 nrst = 1'b0;
        #1;
        n_total++; if ({stall, cache_we, bus.iram_req} !== 3'b000) $display("FAIL reset_ctl: got %b expected 000", {stall, cache_we, bus.iram_req}); else n_pass++;
        n_total++; if (bus.iram_addr !== 32'h0) $display("FAIL reset_addr: got %h expected 0", bus.iram_addr); else n_pass++;
        n_total++; if (block_out !== '0) $display("FAIL reset_block: got %h expected 0", block_out); else n_pass++;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        int we_cyc, sb, wc; logic [0:BB-1] blk; logic [31:0] first_w;
        clear_cfg(); use_ovr = 1'b1;
        run_miss(32'h0000_0108, we_cyc, blk, sb, wc);
        n_total++; if (we_cyc !== 9) $display("FAIL basic_latency: got %0d expected 9", we_cyc); else n_pass++;
        n_total++; if (wc !== 1) $display("FAIL basic_we_count: got %0d expected 1", wc); else n_pass++;
        n_total++; if (sb !== 0) $display("FAIL basic_stall: got %0d bad cycles expected 0", sb); else n_pass++;
        n_total++; if (grant_q.size() !== NW) $display("FAIL basic_beats: got %0d expected %0d", grant_q.size(), NW); else n_pass++;
        for (int k = 0; k < NW && k < grant_q.size(); k++) begin
            n_total++; if (grant_q[k] !== exp_addr(32'h108, k)) $display("FAIL basic_addr%0d: got %h expected %h", k, grant_q[k], exp_addr(32'h108, k)); else n_pass++;
        end
        first_w = blk[0:31];
        n_total++; if (first_w !== 32'h4433_2211) $display("FAIL basic_slot0: got %h expected 44332211", first_w); else n_pass++;
        n_total++; if (blk !== exp_block(32'h108)) $display("FAIL basic_block: got %h expected %h", blk, exp_block(32'h108)); else n_pass++;
        use_ovr = 1'b0;
    endtask

    task automatic test_delays();
        int we_cyc, sb, wc; logic [0:BB-1] blk; logic [31:0] a;
        clear_cfg(); gnt_dly[2] = 3; rv_dly[2] = 2;
        a = $urandom;
        run_miss(a, we_cyc, blk, sb, wc);
        n_total++; if (addr_changes !== 0) $display("FAIL delay_addr_hold: got %0d changes expected 0", addr_changes); else n_pass++;
        n_total++; if (sb !== 0) $display("FAIL delay_stall: got %0d bad cycles expected 0", sb); else n_pass++;
        n_total++; if (wc !== 1) $display("FAIL delay_we_count: got %0d expected 1", wc); else n_pass++;
        n_total++; if (we_cyc !== 14) $display("FAIL delay_latency: got %0d expected 14", we_cyc); else n_pass++;
        n_total++; if (blk !== exp_block(a)) $display("FAIL delay_block: got %h expected %h", blk, exp_block(a)); else n_pass++;
    endtask

    task automatic test_flush_wait();
        int guard, st_cnt, we_seen;
        clear_cfg(); rv_dly[1] = 3;
        @(negedge clk);
        pc = $urandom; fetch_valid = 1'b1; hit = 1'b0;
        guard = 0;
        while (!(n_grants == 2 && !bus.iram_req) && guard < 100) begin
            @(negedge clk); guard++;
        end
        n_total++; if (guard >= 100) $display("FAIL flushw_reach: got timeout expected WAIT of beat 1"); else n_pass++;
        flush = 1'b1; fetch_valid = 1'b0;
        st_cnt = 0; we_seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            flush = 1'b0;
            if (stall === 1'b1) st_cnt++;
            if (cache_we === 1'b1) we_seen++;
        end
        // DRAIN lasts until the rvalid still owed for beat 1 (3 cycles late)
        n_total++; if (st_cnt !== 3) $display("FAIL flushw_drain: got %0d stall cycles expected 3", st_cnt); else n_pass++;
        n_total++; if (we_seen !== 0) $display("FAIL flushw_we: got %0d expected 0", we_seen); else n_pass++;
        n_total++; if ({stall, bus.iram_req} !== 2'b00) $display("FAIL flushw_idle: got %b expected 00", {stall, bus.iram_req}); else n_pass++;
        n_total++; if (n_grants !== 2) $display("FAIL flushw_grants: got %0d expected 2", n_grants); else n_pass++;
    endtask

    task automatic test_flush_req();
        clear_cfg(); gnt_dly[0] = 3;
        @(negedge clk);
        pc = $urandom; fetch_valid = 1'b1; hit = 1'b0;
        @(negedge clk);
        n_total++; if (bus.iram_req !== 1'b1) $display("FAIL flushr_req: got %b expected 1", bus.iram_req); else n_pass++;
        flush = 1'b1; fetch_valid = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        n_total++; if ({stall, bus.iram_req} !== 2'b00) $display("FAIL flushr_idle: got %b expected 00", {stall, bus.iram_req}); else n_pass++;
        repeat (6) @(negedge clk);
        n_total++; if (n_grants !== 0) $display("FAIL flushr_grants: got %0d expected 0", n_grants); else n_pass++;
    endtask

    task automatic test_async_reset();
        int guard, we_cyc, sb, wc; logic [0:BB-1] blk; logic [31:0] a;
        clear_cfg(); rv_dly[0] = 4;
        @(negedge clk);
        pc = $urandom; fetch_valid = 1'b1; hit = 1'b0;
        guard = 0;
        while (!(n_grants == 1 && !bus.iram_req) && guard < 100) begin
            @(negedge clk); guard++;
        end
        #2 nrst = 1'b0; fetch_valid = 1'b0;
        #1;
        n_total++; if ({stall, cache_we, bus.iram_req} !== 3'b000) $display("FAIL arst_ctl: got %b expected 000", {stall, cache_we, bus.iram_req}); else n_pass++;
        n_total++; if (bus.iram_addr !== 32'h0) $display("FAIL arst_addr: got %h expected 0", bus.iram_addr); else n_pass++;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        repeat (6) @(negedge clk);
        clear_cfg();
        a = $urandom;
        run_miss(a, we_cyc, blk, sb, wc);
        n_total++; if (grant_q.size() < 1 || grant_q[0] !== exp_addr(a, 0)) $display("FAIL arst_beat0: got %0d grants expected first %h", grant_q.size(), exp_addr(a, 0)); else n_pass++;
        n_total++; if (we_cyc !== 9 || wc !== 1) $display("FAIL arst_refill: got cycle %0d count %0d expected 9 and 1", we_cyc, wc); else n_pass++;
        n_total++; if (blk !== exp_block(a)) $display("FAIL arst_block: got %h expected %h", blk, exp_block(a)); else n_pass++;
    endtask

    task automatic test_hit_wrap();
        int bad, we_cyc, sb, wc; logic [0:BB-1] blk; logic [31:0] a;
        clear_cfg(); bad = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            pc = $urandom; fetch_valid = 1'b1; hit = 1'b1;
            #1;
            if (stall !== 1'b0 || bus.iram_req !== 1'b0) bad++;
        end
        n_total++; if (bad !== 0) $display("FAIL hit_nostall: got %0d bad cycles expected 0", bad); else n_pass++;
        a = 32'hFFFF_FFFC;
        run_miss(a, we_cyc, blk, sb, wc);
        bad = 0;
        for (int k = 0; k < grant_q.size(); k++)
            if (grant_q[k] !== exp_addr(a, k) || grant_q[k] < 32'hFFFF_FFF0) bad++;
        n_total++; if (bad !== 0 || grant_q.size() !== NW) $display("FAIL wrap_addrs: got %0d bad of %0d expected 0 of %0d", bad, grant_q.size(), NW); else n_pass++;
        n_total++; if (blk !== exp_block(a) || wc !== 1) $display("FAIL wrap_block: got %h expected %h", blk, exp_block(a)); else n_pass++;
    endtask

    task automatic test_random();
        int we_cyc, sb, wc, exp_cyc, bad_addr; logic [0:BB-1] blk; logic [31:0] a;
        for (int n = 0; n < 12; n++) begin
            clear_cfg();
            mem_seed = $urandom;
            exp_cyc = 2 * NW + 1;
            for (int k = 0; k < NW; k++) begin
                gnt_dly[k] = $urandom_range(0, 3);
                rv_dly[k]  = $urandom_range(0, 3);
                exp_cyc += gnt_dly[k] + rv_dly[k];
            end
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                pc = $urandom; fetch_valid = $urandom_range(0, 1); hit = 1'b1;
            end
            a = $urandom;
            run_miss(a, we_cyc, blk, sb, wc);
            bad_addr = (grant_q.size() == NW) ? 0 : 1;
            for (int k = 0; k < grant_q.size(); k++)
                if (grant_q[k] !== exp_addr(a, k)) bad_addr++;
            n_total++; if (bad_addr !== 0) $display("FAIL rnd%0d_addrs: got %0d bad expected 0", n, bad_addr); else n_pass++;
            n_total++; if (blk !== exp_block(a)) $display("FAIL rnd%0d_block: got %h expected %h", n, blk, exp_block(a)); else n_pass++;
            n_total++; if (we_cyc !== exp_cyc || wc !== 1) $display("FAIL rnd%0d_timing: got cycle %0d count %0d expected %0d and 1", n, we_cyc, wc, exp_cyc); else n_pass++;
            n_total++; if (sb !== 0 || addr_changes !== 0) $display("FAIL rnd%0d_handshake: got stall_bad %0d addr_changes %0d expected 0", n, sb, addr_changes); else n_pass++;
        end
    endtask

    initial begin
        mem_seed = $urandom;
        clear_cfg();
        test_reset();
        test_basic();
        test_delays();
        test_flush_wait();
        test_flush_req();
        test_async_reset();
        test_hit_wrap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_icache_refill_ctrl
`default_nettype wire
